// File: rtl/mult_acc_stage.sv
// Dot-product stage behind a 4x4 pipelined multiplier: gates operand issue, tracks the
// multiplier latency with a valid shift chain and saturating-accumulates N_TERMS products.
module mult_acc_stage #(
   parameter int MULT_LAT = 4,
   parameter int PROD_W   = 8,
   parameter int N_TERMS  = 4,
   parameter int ACC_W    = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_sat
);

   localparam int CNT_W = $clog2(N_TERMS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_TERMS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t              state_q, state_d;
   logic [MULT_LAT-1:0] chain_q, chain_d;
   logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]    term_cnt_q, term_cnt_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                sat_q, sat_d;

   logic                in_fire;
   logic                prod_vld;
   logic [ACC_W:0]      sum;

   assign in_ready  = (state_q != HOLD) && (issue_cnt_q < CNT_MAX);
   assign in_fire   = in_valid && in_ready;
   assign prod_vld  = chain_q[MULT_LAT-1];
   assign sum       = {1'b0, acc_q} + (ACC_W+1)'(prod);

   assign out_valid = (state_q == HOLD);
   assign out_sum   = acc_q;
   assign out_sat   = sat_q;

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      term_cnt_d  = term_cnt_q;
      acc_d       = acc_q;
      sat_d       = sat_q;
      chain_d     = '0;

      chain_d[0] = in_fire;
      for (int i = 1; i < MULT_LAT; i++) begin
         chain_d[i] = chain_q[i-1];
      end

      if (in_fire) begin
         issue_cnt_d = issue_cnt_q + CNT_ONE;
      end

      // The carry bit of the widened sum is the overflow flag; sat stays set for the vector.
      if (prod_vld) begin
         term_cnt_d = term_cnt_q + CNT_ONE;
         if (sum[ACC_W]) begin
            acc_d = '1;
            sat_d = 1'b1;
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
      end

      case (state_q)
         IDLE: if (in_fire) state_d = ACC;
         ACC:  if (prod_vld && (term_cnt_q == CNT_LAST)) state_d = HOLD;
         HOLD: begin
            if (out_ready) begin
               state_d     = IDLE;
               acc_d       = '0;
               sat_d       = 1'b0;
               issue_cnt_d = '0;
               term_cnt_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort drops partial sums and every product still inside the multiplier.
      if (clr) begin
         state_d     = IDLE;
         acc_d       = '0;
         sat_d       = 1'b0;
         issue_cnt_d = '0;
         term_cnt_d  = '0;
         chain_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         chain_q     <= '0;
         issue_cnt_q <= '0;
         term_cnt_q  <= '0;
         acc_q       <= '0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         chain_q     <= chain_d;
         issue_cnt_q <= issue_cnt_d;
         term_cnt_q  <= term_cnt_d;
         acc_q       <= acc_d;
         sat_q       <= sat_d;
      end
   end

   // Issue gating makes a product beyond the last term impossible.
   a_no_extra_term: assert property (@(posedge clk) disable iff (rst)
      !(prod_vld && (term_cnt_q == CNT_MAX)));

endmodule
